port_input_debounce: RTL



---
 rtl/port_input_debounce_pkg.sv | 18 +
 rtl/port_input_debounce_debounce_bit.sv | 51 +++++
 rtl/port_input_debounce.sv | 66 ++++++
 3 files changed

// File: rtl/port_input_debounce_pkg.sv
// Shared constants and sizing helpers for the SoC port input path.
package port_io_pkg;

   localparam int unsigned PORT_WIDTH        = 8;
   localparam int unsigned DEBOUNCE_TICK_DIV = 1024;
   localparam int unsigned DEBOUNCE_TICKS    = 16;

   // Counter must hold 0..ticks-1 with headroom, matching the legacy sizing.
   function automatic int unsigned cnt_width(input int unsigned ticks);
      return $clog2(ticks) + 1;
   endfunction

   // A divide-by-1 prescaler still needs a one-bit register.
   function automatic int unsigned presc_width(input int unsigned div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/port_input_debounce_debounce_bit.sv
// One pin: two-flop synchronizer, tick-driven debounce counter and press/update events.
module debounce_bit
   import port_io_pkg::*;
#(
   parameter int unsigned DEBOUNCE_TICKS = port_io_pkg::DEBOUNCE_TICKS
) (
   input  logic clk,
   input  logic reset,
   input  logic pin_n,
   input  logic tick,
   output logic stable,
   output logic press,
   output logic update
);

   localparam int unsigned       CW      = cnt_width(DEBOUNCE_TICKS);
   localparam logic [CW-1:0]     CNT_MAX = CW'(DEBOUNCE_TICKS - 1);

   logic          s1;
   logic          s2;
   logic          level;
   logic [CW-1:0] cnt;

   assign level  = ~s2;
   // The accepting edge is the last tick of a full mismatch run.
   assign update = tick && (level != stable) && (cnt == CNT_MAX);
   assign press  = update && level;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1     <= 1'b1;
         s2     <= 1'b1;
         cnt    <= '0;
         stable <= 1'b0;
      end else begin
         s1 <= pin_n;
         s2 <= s1;
         if (level == stable) begin
            cnt <= '0;
         end else if (tick) begin
            if (cnt == CNT_MAX) begin
               stable <= level;
               cnt    <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/port_input_debounce.sv
// Board pins to SoC input port: shared debounce prescaler, per-bit debouncers, press IRQ latches.
module port_input_debounce
   import port_io_pkg::*;
#(
   parameter int unsigned WIDTH          = PORT_WIDTH,
   parameter int unsigned TICK_DIV       = DEBOUNCE_TICK_DIV,
   parameter int unsigned DEBOUNCE_TICKS = port_io_pkg::DEBOUNCE_TICKS
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pins_n,
   output logic [WIDTH-1:0] port_value,
   output logic             changed,
   output logic [WIDTH-1:0] irq,
   input  logic [WIDTH-1:0] irq_clear
);

   localparam int unsigned   PW        = presc_width(TICK_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   logic [PW-1:0]    presc;
   logic             tick;
   logic [WIDTH-1:0] press;
   logic [WIDTH-1:0] update;

   assign tick = (presc == PRESC_MAX);

   always_ff @(posedge clk) begin
      if (reset) begin
         presc <= '0;
      end else if (tick) begin
         presc <= '0;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   genvar g;
   generate
      for (g = 0; g < WIDTH; g++) begin : g_bit
         debounce_bit #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
         ) u_bit (
            .clk    (clk),
            .reset  (reset),
            .pin_n  (pins_n[g]),
            .tick   (tick),
            .stable (port_value[g]),
            .press  (press[g]),
            .update (update[g])
         );
      end
   endgenerate

   // Set outranks clear so a press coinciding with a clear is never lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         irq     <= '0;
         changed <= 1'b0;
      end else begin
         irq     <= press | (irq & ~irq_clear);
         changed <= |update;
      end
   end

endmodule
